// File: rtl/frame_synchronizer.sv
// Frame synchronizer: hunts for a sync word in a strobed serial bit stream,
// confirms it over consecutive frames, then deserialises payload bytes
// MSB-first while flywheeling through isolated sync misses.
module frame_synchronizer #(
    parameter int                SYNC_W        = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD     = 16'hEB90,
    parameter int                PAYLOAD_BYTES = 4,
    parameter int                CONFIRM       = 2,
    parameter int                MISS_LIMIT    = 3
) (
    input  logic       receiver_LO,
    input  logic       receiver_rst,
    input  logic       bit_i,
    input  logic       bit_valid_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       frame_start_o,
    output logic       locked_o
);

    localparam int FRAME_BITS = SYNC_W + 8 * PAYLOAD_BYTES;
    localparam int PAY_BITS   = 8 * PAYLOAD_BYTES;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    // Position of the last bit of the next expected sync word.
    localparam logic [CNT_W-1:0] SLOT_CNT     = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] PAY_LAST_CNT = CNT_W'(PAY_BITS - 1);
    localparam logic [2:0]       CONF_TGT     = 3'(CONFIRM);
    localparam logic [2:0]       MISS_TGT     = 3'(MISS_LIMIT);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [SYNC_W-1:0] sr_q,      sr_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]        conf_q,    conf_d;
    logic [2:0]        miss_q,    miss_d;
    logic [7:0]        byte_q,    byte_d;
    logic [7:0]        data_q,    data_d;
    logic              dv_q,      dv_d;
    logic              fs_q,      fs_d;
    logic              lock_q,    lock_d;

    // The sync comparison always looks at the shift register including the
    // bit arriving this cycle.
    logic [SYNC_W-1:0] nxt_sr;
    logic              sync_hit;
    logic              at_slot;
    logic [CNT_W-1:0]  cnt_adv;
    logic [7:0]        byte_shift;

    assign nxt_sr     = {sr_q[SYNC_W-2:0], bit_i};
    assign sync_hit   = (nxt_sr == SYNC_WORD);
    assign at_slot    = (bit_cnt_q == SLOT_CNT);
    assign cnt_adv    = at_slot ? {CNT_W{1'b0}} : (bit_cnt_q + CNT_W'(1));
    assign byte_shift = {byte_q[6:0], bit_i};

    // Next-state and output decode: hunt / confirm / locked deserialisation.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        conf_d    = conf_q;
        miss_d    = miss_q;
        byte_d    = byte_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        fs_d      = 1'b0;

        if (bit_valid_i) begin
            sr_d = nxt_sr;
            case (state_q)
                ST_HUNT: begin
                    if (sync_hit) begin
                        bit_cnt_d = {CNT_W{1'b0}};
                        miss_d    = 3'd0;
                        if (CONF_TGT == 3'd1) begin
                            state_d = ST_LOCK;
                            conf_d  = 3'd0;
                            fs_d    = 1'b1;
                        end else begin
                            state_d = ST_CHECK;
                            conf_d  = 3'd1;
                        end
                    end else begin
                        bit_cnt_d = {CNT_W{1'b0}};
                    end
                end
                ST_CHECK: begin
                    bit_cnt_d = cnt_adv;
                    if (at_slot) begin
                        if (sync_hit) begin
                            if ((conf_q + 3'd1) == CONF_TGT) begin
                                state_d = ST_LOCK;
                                conf_d  = 3'd0;
                                miss_d  = 3'd0;
                                fs_d    = 1'b1;
                            end else begin
                                conf_d = conf_q + 3'd1;
                            end
                        end else begin
                            state_d   = ST_HUNT;
                            conf_d    = 3'd0;
                            bit_cnt_d = {CNT_W{1'b0}};
                        end
                    end else begin
                        conf_d = conf_q;
                    end
                end
                ST_LOCK: begin
                    bit_cnt_d = cnt_adv;
                    if (bit_cnt_q <= PAY_LAST_CNT) begin
                        byte_d = byte_shift;
                        if (bit_cnt_q[2:0] == 3'b111) begin
                            data_d = byte_shift;
                            dv_d   = 1'b1;
                        end else begin
                            data_d = data_q;
                        end
                    end else begin
                        byte_d = byte_q;
                    end
                    if (at_slot) begin
                        if (sync_hit) begin
                            miss_d = 3'd0;
                            fs_d   = 1'b1;
                        end else if ((miss_q + 3'd1) == MISS_TGT) begin
                            // Lock lost: drop any partial byte and restart the search.
                            state_d   = ST_HUNT;
                            miss_d    = 3'd0;
                            byte_d    = 8'd0;
                            bit_cnt_d = {CNT_W{1'b0}};
                        end else begin
                            miss_d = miss_q + 3'd1;
                        end
                    end else begin
                        miss_d = miss_q;
                    end
                end
                default: begin
                    state_d   = ST_HUNT;
                    bit_cnt_d = {CNT_W{1'b0}};
                    conf_d    = 3'd0;
                    miss_d    = 3'd0;
                    byte_d    = 8'd0;
                end
            endcase
        end else begin
            sr_d = sr_q;
        end

        lock_d = (state_d == ST_LOCK);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge receiver_LO or posedge receiver_rst) begin
        if (receiver_rst) begin
            state_q   <= ST_HUNT;
            sr_q      <= {SYNC_W{1'b0}};
            bit_cnt_q <= {CNT_W{1'b0}};
            conf_q    <= 3'd0;
            miss_q    <= 3'd0;
            byte_q    <= 8'd0;
            data_q    <= 8'd0;
            dv_q      <= 1'b0;
            fs_q      <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            conf_q    <= conf_d;
            miss_q    <= miss_d;
            byte_q    <= byte_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fs_q      <= fs_d;
            lock_q    <= lock_d;
        end
    end

    assign data_o        = data_q;
    assign data_valid_o  = dv_q;
    assign frame_start_o = fs_q;
    assign locked_o      = lock_q;

endmodule

// File: tb/tb_frame_synchronizer.sv
// Self-checking bench for frame_synchronizer: frame table, directed corner
// sequences and randomized streams compared against a history-based model.
module tb_frame_synchronizer;

    localparam int          FB    = 48;
    localparam int          PB    = 4;
    localparam int          CONF  = 2;
    localparam int          MISSL = 3;
    localparam logic [15:0] SYNC  = 16'hEB90;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_i;
    logic       bit_valid_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       frame_start_o;
    logic       locked_o;

    always #5 clk = ~clk;

    frame_synchronizer #(
        .SYNC_W(16), .SYNC_WORD(SYNC), .PAYLOAD_BYTES(PB),
        .CONFIRM(CONF), .MISS_LIMIT(MISSL)
    ) dut (
        .receiver_LO  (clk),
        .receiver_rst (rst),
        .bit_i        (bit_i),
        .bit_valid_i  (bit_valid_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .frame_start_o(frame_start_o),
        .locked_o     (locked_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on the absolute history of received bits: the anchor is the index
    // of the bit that ended the last accepted/expected sync word.
    bit         hist[$];
    int         m_mode;   // 0 hunt, 1 confirming, 2 locked
    int         m_anchor;
    int         m_conf;
    int         m_miss;
    logic       e_dv, e_fs, e_lk;
    logic [7:0] e_data;

    task automatic model_reset();
        hist.delete();
        m_mode = 0; m_anchor = 0; m_conf = 0; m_miss = 0;
        e_dv = 1'b0; e_fs = 1'b0; e_lk = 1'b0; e_data = 8'd0;
    endtask

    function automatic logic [15:0] window_at(int p);
        logic [15:0] w;
        w = 16'd0;
        for (int i = p - 15; i <= p; i++) begin
            if (i >= 0) w = {w[14:0], logic'(hist[i])};
            else        w = {w[14:0], 1'b0};
        end
        return w;
    endfunction

    task automatic model_step(input logic b);
        int   p;
        int   off;
        logic match;
        hist.push_back(b);
        p     = hist.size() - 1;
        match = (window_at(p) == SYNC);
        off   = p - m_anchor;
        e_dv  = 1'b0;
        e_fs  = 1'b0;
        case (m_mode)
            0: if (match) begin
                m_anchor = p; m_conf = 1;
                if (CONF == 1) begin m_mode = 2; m_miss = 0; e_fs = 1'b1; end
                else m_mode = 1;
            end
            1: if (off == FB) begin
                if (match) begin
                    m_conf++; m_anchor = p;
                    if (m_conf == CONF) begin m_mode = 2; m_miss = 0; e_fs = 1'b1; end
                end else begin
                    m_mode = 0; m_conf = 0;
                end
            end
            2: begin
                if (off <= 8 * PB && (off % 8) == 0) begin
                    e_dv = 1'b1;
                    for (int k = p - 7; k <= p; k++) e_data = {e_data[6:0], logic'(hist[k])};
                end
                if (off == FB) begin
                    m_anchor = p;
                    if (match) begin m_miss = 0; e_fs = 1'b1; end
                    else begin
                        m_miss++;
                        if (m_miss == MISSL) begin m_mode = 0; m_miss = 0; end
                    end
                end
            end
            default: m_mode = 0;
        endcase
        e_lk = (m_mode == 2);
    endtask

    // ---------------- stimulus / observation ----------------
    logic [7:0] obs_bytes[$];
    int         fs_seen;
    int         lk_seen;

    task automatic sample_check(input string tag);
        chk({tag, " data_valid"}, 32'(data_valid_o), 32'(e_dv));
        chk({tag, " frame_start"}, 32'(frame_start_o), 32'(e_fs));
        chk({tag, " locked"}, 32'(locked_o), 32'(e_lk));
        if (e_dv) chk({tag, " data"}, 32'(data_o), 32'(e_data));
        if (data_valid_o === 1'b1) obs_bytes.push_back(data_o);
        if (frame_start_o === 1'b1) fs_seen++;
        if (locked_o === 1'b1) lk_seen++;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_i       = b;
        bit_valid_i = 1'b1;
        model_step(b);
        @(posedge clk);
        #1;
        sample_check("bit");
        bit_valid_i = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        bit_valid_i = 1'b0;
        bit_i       = 1'($urandom);
        e_dv = 1'b0;
        e_fs = 1'b0;
        @(posedge clk);
        #1;
        sample_check("idle");
    endtask

    task automatic send_bits(input logic [63:0] value, input int n, input int gap_max);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(value[i]);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) idle();
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bit_valid_i = 1'b0;
        #1;
        chk("reset data_o", 32'(data_o), 32'd0);
        chk("reset data_valid", 32'(data_valid_o), 32'd0);
        chk("reset frame_start", 32'(frame_start_o), 32'd0);
        chk("reset locked", 32'(locked_o), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] sync;
        logic [31:0] payload;
        int          exp_fs;
        logic        exp_lock;
        logic        exp_out;
    } frame_vec_t;

    frame_vec_t tbl[8];

    initial begin
        logic [31:0] pl;
        logic        lk_after;
        int          fs_sync;
        logic [15:0] sw;

        pl = 32'h11223344;
        tbl[0] = '{16'hEB90, 32'h11223344, 0, 1'b0, 1'b0};
        tbl[1] = '{16'hEB90, 32'h11223344, 1, 1'b1, 1'b1};
        tbl[2] = '{16'hEB90, 32'h11223344, 1, 1'b1, 1'b1};
        tbl[3] = '{16'hEB91, 32'h11223344, 0, 1'b1, 1'b1};
        tbl[4] = '{16'hEB91, 32'h11223344, 0, 1'b1, 1'b1};
        tbl[5] = '{16'hEB91, 32'h11223344, 0, 1'b0, 1'b0};
        tbl[6] = '{16'hEB90, 32'h11223344, 0, 1'b0, 1'b0};
        tbl[7] = '{16'hEB90, 32'h11223344, 1, 1'b1, 1'b1};

        rst = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0;
        model_reset();
        #2;

        // Frame table: acquisition, flywheel over two bad syncs, loss, reacquire.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            fs_seen = 0;
            obs_bytes.delete();
            send_bits(64'(tbl[i].sync), 16, 0);
            lk_after = locked_o;
            fs_sync  = fs_seen;
            obs_bytes.delete();
            send_bits(64'(tbl[i].payload), 32, 0);
            chk($sformatf("tbl%0d frame_start count", i), 32'(fs_sync), 32'(tbl[i].exp_fs));
            chk($sformatf("tbl%0d locked after sync", i), 32'(lk_after), 32'(tbl[i].exp_lock));
            chk($sformatf("tbl%0d byte count", i), 32'(obs_bytes.size()), tbl[i].exp_out ? 32'd4 : 32'd0);
            if (tbl[i].exp_out && obs_bytes.size() == 4)
                for (int j = 0; j < 4; j++)
                    chk($sformatf("tbl%0d byte%0d", i, j), 32'(obs_bytes[j]), 32'(tbl[i].payload[31-8*j -: 8]));
        end

        // Sparse strobes: same stream, same byte sequence.
        do_reset();
        obs_bytes.delete();
        for (int f = 0; f < 4; f++) begin
            send_bits(64'(SYNC), 16, 4);
            send_bits(64'(pl), 32, 4);
        end
        chk("sparse byte count", 32'(obs_bytes.size()), 32'd12);
        if (obs_bytes.size() == 12)
            for (int j = 0; j < 12; j++)
                chk($sformatf("sparse byte%0d", j), 32'(obs_bytes[j]), 32'(pl[31-8*(j%4) -: 8]));

        // False sync in hunt followed by a non-sync at the next slot.
        do_reset();
        lk_seen = 0;
        send_bits(64'h0, 8, 0);
        send_bits(64'(SYNC), 16, 0);
        send_bits(64'h0, 48, 0);
        chk("false sync lock count", 32'(lk_seen), 32'd0);
        send_bits(64'(SYNC), 16, 0);
        send_bits(64'(pl), 32, 0);
        chk("false sync then check", 32'(locked_o), 32'd0);
        send_bits(64'(SYNC), 16, 0);
        chk("true sync acquired", 32'(locked_o), 32'd1);

        // Reset in the middle of a locked payload byte.
        do_reset();
        send_bits({SYNC, pl}, 48, 0);
        send_bits(64'(SYNC), 16, 0);
        send_bits(64'(pl >> 20), 12, 0);
        chk("mid-payload locked", 32'(locked_o), 32'd1);
        do_reset();
        obs_bytes.delete();
        send_bits({SYNC, pl}, 48, 0);
        chk("post-reset not locked", 32'(locked_o), 32'd0);
        chk("post-reset no bytes", 32'(obs_bytes.size()), 32'd0);
        send_bits(64'(SYNC), 16, 0);
        chk("post-reset reacquired", 32'(locked_o), 32'd1);

        // Constant streams never hit the sync word.
        do_reset();
        fs_seen = 0; lk_seen = 0; obs_bytes.delete();
        for (int i = 0; i < 4; i++) send_bits(64'h0, 50, 1);
        for (int i = 0; i < 4; i++) send_bits(64'hFFFF_FFFF_FFFF_FFFF, 50, 1);
        chk("const frame_start", 32'(fs_seen), 32'd0);
        chk("const locked", 32'(lk_seen), 32'd0);
        chk("const bytes", 32'(obs_bytes.size()), 32'd0);

        // Randomized frames with noise slips, corrupted syncs and gaps.
        do_reset();
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) == 0)
                send_bits({$urandom, $urandom}, $urandom_range(1, 20), 2);
            sw = SYNC;
            if ($urandom_range(0, 99) < 15) sw = sw ^ (16'h1 << $urandom_range(0, 15));
            send_bits(64'(sw), 16, 2);
            send_bits(64'($urandom), 32, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
